muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file read ports and consumes the registered DataA/DataB operands. It computes all eight M-extension operations over multiple cycles and drives the register file write port (AddrD/DataD/RegWEn) with the result.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- funct3  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- DataA  in  32  rs1 operand (dividend / multiplicand).
- DataB  in  32  rs2 operand (divisor / multiplier).
- rd_in  in  5  destination register index.
- busy  out  1  high from accepted start until the return to IDLE.
- done  out  1  one-cycle result-valid pulse.
- AddrD  out  5  write address to the register file.
- DataD  out  32  result to the register file.
- RegWEn  out  1  register file write enable.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: start=1 captures funct3, DataA, DataB and rd_in, loads a 5-bit counter with 0, and moves to CALC. Operands may change after capture.
  - CALC: one radix-2 step per cycle; the counter increments; after the 32nd step go to FIX.
  - FIX: apply sign correction and special-case selection, load DataD/AddrD, then go to DONE.
  - DONE: done=1 and RegWEn=(AddrD!=0); next state IDLE.
- Signed handling:
  - Signed operands are converted to magnitudes at capture.
  - MULH: both operands signed. MULHSU: rs1 signed only. MULHU/DIVU/REMU: unsigned.
- Multiply: unsigned shift-add into a 64-bit accumulator. The product is negated in FIX if the operand signs differ. MUL returns bits [31:0]; MULH* return bits [63:32].
- Divide: restoring shift-subtract on magnitudes.
  - Quotient is negated if operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
- Special cases (always required):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Write-back: rd_in=0 still produces done, but RegWEn stays 0.

## Timing
- Reset values: busy=0, done=0, RegWEn=0, DataD=0, AddrD=0, state IDLE, counter 0.
- With start accepted at edge T0:
  - CALC occupies edges T1..T32; FIX at T33.
  - done, RegWEn, DataD and AddrD are valid for the cycle after T33 (latency 34 cycles from the start edge, one cycle wide).
  - IDLE is re-entered at T34; busy falls then.
- Outputs are registered and stable for the whole DONE cycle, so the register file's negedge write captures them mid-cycle.
- start while busy=1 (CALC/FIX/DONE): ignored, no queueing. start in the same cycle busy falls is accepted.
- rst_n low at any point: immediate return to IDLE with all outputs at reset values. An interrupted operation never produces done or RegWEn.
- DataA/DataB come from the register file's posedge-registered read. The issuing logic raises start in the cycle after the read addresses are presented.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - Divide-by-zero, signed overflow, and any MUL* operation with a zero operand go from IDLE straight to DONE at T0, skipping CALC and FIX.
  - done is high in the cycle after T0 (latency 1).
  - Result values are as specified above.
- Undefined: every operation takes the full 34-cycle latency. Results are identical.

## Test plan
- MUL with DataA=7, DataB=0xFFFFFFFD, rd_in=5 → DataD=0xFFFFFFEB, AddrD=5; done and RegWEn high for exactly one cycle, 34 cycles after the start edge.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Latency is 1 with MULDIV_EARLY_OUT_EN and 34 without.
- start re-pulsed mid-CALC → ignored, first result unchanged. rst_n pulsed low at CALC step 10 → busy=0 immediately, no RegWEn; a following MUL 3×4 → 12.
- MUL 6×7 with rd_in=0 → done pulses with DataD=42; RegWEn stays 0 throughout.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps, then sign fix-up and register-file write-back.
// Optional MULDIV_EARLY_OUT_EN: trivial cases (div-by-zero, signed overflow, zero multiply operand) finish in one cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] DataA,
    input  logic [31:0] DataB,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [4:0]  AddrD,
    output logic [31:0] DataD,
    output logic        RegWEn
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_reg;
    logic [2:0]  op_reg;
    logic [4:0]  rd_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] opb_reg;
    logic        neg_res_reg;
    logic        neg_rem_reg;
    logic        special_reg;
    logic [31:0] special_val_reg;

    // Operand conditioning at capture time
    logic        is_div, sign_a, sign_b, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, div_ovf, special_hit;
    logic [31:0] special_val;

    assign is_div   = funct3[2];
    assign sign_a   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sign_b   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg    = sign_a & DataA[31];
    assign b_neg    = sign_b & DataB[31];
    assign mag_a    = a_neg ? -DataA : DataA;
    assign mag_b    = b_neg ? -DataB : DataB;
    assign div_zero = is_div && (DataB == 32'd0);
    assign div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                      (DataA == 32'h8000_0000) && (DataB == 32'hFFFF_FFFF);
    assign special_hit = div_zero | div_ovf;

    // funct3[1] separates REM/REMU from DIV/DIVU within the divide group
    always_comb begin
        special_val = 32'd0;
        if (div_zero)
            special_val = funct3[1] ? DataA : 32'hFFFF_FFFF;
        else if (div_ovf)
            special_val = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic early_hit;
    assign early_hit = special_hit | (!is_div && ((DataA == 32'd0) || (DataB == 32'd0)));
`endif

    // One iteration: multiply shifts the {hi,lo} accumulator right, divide shifts it left
    logic [32:0] mul_sum, div_shift, div_trial;
    logic [31:0] hi_next, lo_next;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : 33'd0);
        div_shift = {hi_reg, lo_reg[31]};
        div_trial = div_shift - {1'b0, opb_reg};
        if (op_reg[2]) begin
            if (!div_trial[32]) begin
                hi_next = div_trial[31:0];
                lo_next = {lo_reg[30:0], 1'b1};
            end else begin
                hi_next = div_shift[31:0];
                lo_next = {lo_reg[30:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[32:1];
            lo_next = {mul_sum[0], lo_reg[31:1]};
        end
    end

    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix, result;

    always_comb begin
        prod     = {hi_reg, lo_reg};
        prod_fix = neg_res_reg ? -prod : prod;
        quo_fix  = neg_res_reg ? -lo_reg : lo_reg;
        rem_fix  = neg_rem_reg ? -hi_reg : hi_reg;
        if (special_reg)
            result = special_val_reg;
        else if (op_reg[2])
            result = op_reg[1] ? rem_fix : quo_fix;
        else
            result = (op_reg[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            op_reg          <= 3'd0;
            rd_reg          <= 5'd0;
            cnt_reg         <= 5'd0;
            hi_reg          <= 32'd0;
            lo_reg          <= 32'd0;
            opb_reg         <= 32'd0;
            neg_res_reg     <= 1'b0;
            neg_rem_reg     <= 1'b0;
            special_reg     <= 1'b0;
            special_val_reg <= 32'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            RegWEn          <= 1'b0;
            DataD           <= 32'd0;
            AddrD           <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg          <= funct3;
                        rd_reg          <= rd_in;
                        cnt_reg         <= 5'd0;
                        hi_reg          <= 32'd0;
                        lo_reg          <= is_div ? mag_a : mag_b;
                        opb_reg         <= is_div ? mag_b : mag_a;
                        neg_res_reg     <= a_neg ^ b_neg;
                        neg_rem_reg     <= a_neg;
                        special_reg     <= special_hit;
                        special_val_reg <= special_val;
                        busy            <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            DataD     <= special_val;
                            AddrD     <= rd_in;
                            done      <= 1'b1;
                            RegWEn    <= (rd_in != 5'd0);
                            state_reg <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
`else
                        state_reg <= CALC;
`endif
                    end
                end
                CALC: begin
                    hi_reg  <= hi_next;
                    lo_reg  <= lo_next;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31)
                        state_reg <= FIX;
                end
                FIX: begin
                    DataD     <= result;
                    AddrD     <= rd_reg;
                    done      <= 1'b1;
                    RegWEn    <= (rd_reg != 5'd0);
                    state_reg <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    RegWEn    <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, and
// randomized operations compared against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] DataA, DataB;
    logic [4:0]  rd_in;
    logic        busy, done, RegWEn;
    logic [4:0]  AddrD;
    logic [31:0] DataD;

    int n_vectors = 0;
    int n_miscompares = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .DataA(DataA), .DataB(DataB), .rd_in(rd_in),
        .busy(busy), .done(done), .AddrD(AddrD), .DataD(DataD), .RegWEn(RegWEn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference results straight from the RV32M definitions using 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit early;
        int lat_early;
        early = (f[2] && (b == 32'd0)) ||
                (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) ||
                (!f[2] && ((a == 32'd0) || (b == 32'd0)));
        lat_early = 34;
`ifdef MULDIV_EARLY_OUT_EN
        lat_early = 1;
`endif
        return early ? lat_early : 34;
    endfunction

    // Issues one operation, optionally re-pulses start mid-operation, then checks the
    // write-back cycle and the return to idle in the following cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input string tag, input bit repulse);
        int n, lat;
        bit got;
        lat = exp_latency(f, a, b);
        @(negedge clk);
        funct3 = f; DataA = a; DataB = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        DataA = $urandom; DataB = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
        n = 0;
        got = 1'b0;
        while (n <= 40) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (repulse && n == 5) begin
                start = 1'b1; DataA = $urandom; DataB = $urandom; rd_in = 5'($urandom);
            end
            if (repulse && n == 6) start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (!got) begin
            chk({tag, "_timeout"}, 64'd1, 64'd0);
            return;
        end
        $display("op f=%0d a=%08h b=%08h rd=%0d -> DataD=%08h AddrD=%0d RegWEn=%0d latency=%0d",
                 f, a, b, rd, DataD, AddrD, RegWEn, n + 1);
        chk({tag, "_latency"}, 64'(n + 1), 64'(lat));
        chk({tag, "_DataD"}, 64'(DataD), 64'(exp));
        chk({tag, "_AddrD"}, 64'(AddrD), 64'(rd));
        chk({tag, "_RegWEn"}, 64'(RegWEn), 64'(rd != 5'd0));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_done_width"}, 64'({done, RegWEn, busy}), 64'd0);
    endtask

    vec_t vecs[13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        logic [31:0] pick[4];

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd8,  32'd2};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,         5'd10, 32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0};
        vecs[12] = '{3'd0, 32'd6,          32'd7,         5'd0,  32'd42};

        rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; DataA = 32'd0; DataB = 32'd0; rd_in = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({busy, done, RegWEn, AddrD, DataD}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

        run_op(3'd0, 32'd1234, 32'd5678, 5'd12, ref_model(3'd0, 32'd1234, 32'd5678), "repulse", 1'b1);

        // Reset asserted after the tenth CALC step must abort silently
        @(negedge clk);
        funct3 = 3'd4; DataA = 32'd1000; DataB = 32'd3; rd_in = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("reset_mid_calc", 64'({busy, done, RegWEn, AddrD, DataD}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || RegWEn || busy) seen = 1'b1;
        end
        chk("no_writeback_after_reset", 64'(seen), 64'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd13, 32'd12, "after_reset", 1'b0);

        for (int i = 0; i < 40; i++) begin
            pick[0] = 32'd0; pick[1] = 32'h8000_0000; pick[2] = 32'hFFFF_FFFF; pick[3] = 32'd1;
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) < 4) ? pick[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 7) < 4) ? pick[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 300);
            run_op(rf, ra, rb, 5'($urandom), ref_model(rf, ra, rb), $sformatf("rand%0d", i), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
